carry_ripple_seq_adder: RTL and testbench

Parametrised multi-cycle ripple-carry adder/subtractor with accumulator, the generalised successor to our fixed 7-bit carry-ripple adder. Operands are accepted over a valid/ready handshake. The block processes DIGIT bits per clock through a single narrow ripple slice, carrying between slices in a register, and presents sum, carry and overflow over a second valid/ready handshake. It sits between the pin-level input capture and output drive logic of the tile.

---
 rtl/carry_ripple_pkg.sv | 25 ++
 rtl/carry_ripple_seq_adder_slice.sv | 32 +++
 rtl/carry_ripple_seq_adder.sv | 153 +++++++++++++++
 tb/tb_carry_ripple_seq_adder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/carry_ripple_pkg.sv
// Shared types and helpers for the multi-cycle ripple adder.
// Modes, FSM states and chunk count.
package carry_ripple_pkg;

  typedef enum logic [1:0] {
    ADD     = 2'b00,
    SUB     = 2'b01,
    ACC_ADD = 2'b10,
    ACC_SUB = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic int nchunk(
    input int w,
    input int d
  );
    return (w + d - 1) / d;
  endfunction

endpackage

// File: rtl/carry_ripple_seq_adder_slice.sv
// Combinational W-bit ripple slice.
// TAP marks the bit whose carry in/out is reported for flags.
module rca_slice #(
  parameter int W   = 1,
  parameter int TAP = W - 1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         ci_i,
  output logic [W-1:0] s_o,
  output logic         co_o,
  output logic         ct_o,
  output logic         cm_o
);

  logic [W:0] c;

  always_comb begin
    c[0] = ci_i;
    s_o  = '0;
    for (int i = 0; i < W; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i])
               | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign co_o = c[W];
  assign ct_o = c[TAP+1];
  assign cm_o = c[TAP];

endmodule

// File: rtl/carry_ripple_seq_adder.sv
// Multi-cycle ripple adder/subtractor with accumulator.
// DIGIT bits per clock through one slice; carry kept in c_q.
module carry_ripple_seq_adder
  import carry_ripple_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       mode,
  input  logic             cin,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NCHUNK = nchunk(WIDTH, DIGIT);
  localparam int PW     = NCHUNK * DIGIT;
  localparam int P      = WIDTH - 1 - (NCHUNK - 1) * DIGIT;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

  state_e state_q, state_d;

  logic [PW-1:0]    a_q, b_q, sum_q;
  logic [PW-1:0]    a_ld, b_ld, sum_nx;
  logic [KW-1:0]    k_q;
  logic             c_q, c0;
  logic [WIDTH-1:0] acc_q;
  logic             cout_q, ovf_q;

  logic             accept, last;
  logic [DIGIT-1:0] s;
  logic             co, ct, cm;
  mode_e            m;

  assign m      = mode_e'(mode);
  assign accept = in_valid & in_ready;
  assign last   = (state_q == RUN) && (k_q == KLAST);

  rca_slice #(
    .W   (DIGIT),
    .TAP (P)
  ) u_slice (
    .a_i  (a_q[DIGIT-1:0]),
    .b_i  (b_q[DIGIT-1:0]),
    .ci_i (c_q),
    .s_o  (s),
    .co_o (co),
    .ct_o (ct),
    .cm_o (cm)
  );

  always_comb begin
    a_ld = '0;
    b_ld = '0;
    c0   = cin;
    unique case (1'b1)
      (m == ADD): begin
        a_ld[WIDTH-1:0] = op_a;
        b_ld[WIDTH-1:0] = op_b;
      end
      (m == SUB): begin
        a_ld[WIDTH-1:0] = op_a;
        b_ld[WIDTH-1:0] = ~op_b;
        c0              = 1'b1;
      end
      (m == ACC_ADD): begin
        a_ld[WIDTH-1:0] = acc_q;
        b_ld[WIDTH-1:0] = op_b;
      end
      default: begin
        a_ld[WIDTH-1:0] = acc_q;
        b_ld[WIDTH-1:0] = ~op_b;
        c0              = 1'b1;
      end
    endcase
  end

  if (NCHUNK == 1) begin : g_one
    assign sum_nx = s;
  end else begin : g_many
    assign sum_nx = {s, sum_q[PW-1:DIGIT]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      k_q    <= '0;
      c_q    <= 1'b0;
      acc_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) begin
        a_q <= a_ld;
        b_q <= b_ld;
        c_q <= c0;
        k_q <= '0;
      end else if (state_q == RUN) begin
        a_q   <= a_q >> DIGIT;
        b_q   <= b_q >> DIGIT;
        sum_q <= sum_nx;
        c_q   <= co;
        k_q   <= k_q + 1'b1;
        // flags come from bit WIDTH-1, never the pad bits
        if (last) begin
          cout_q <= ct;
          ovf_q  <= ct ^ cm;
        end
      end
      if (acc_clr)   acc_q <= '0;
      else if (last) acc_q <= sum_nx[WIDTH-1:0];
    end
  end

  assign sum  = sum_q[WIDTH-1:0];
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_carry_ripple_seq_adder.sv
// Randomised + directed bench for carry_ripple_seq_adder.
// Two instances: DIGIT=1 and DIGIT=3, WIDTH=7.
module tb_carry_ripple_seq_adder;

  localparam int W    = 7;
  localparam int MOD  = 1 << W;
  localparam int HALF = MOD / 2;
  localparam logic [1:0] M_ADD  = 2'd0;
  localparam logic [1:0] M_SUB  = 2'd1;
  localparam logic [1:0] M_AADD = 2'd2;
  localparam logic [1:0] M_ASUB = 2'd3;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic [W-1:0] op_a      = '0;
  logic [W-1:0] op_b      = '0;
  logic [1:0]   mode      = '0;
  logic         cin       = 1'b0;
  logic         acc_clr   = 1'b0;
  logic         out_ready = 1'b1;

  logic         iv [2] = '{1'b0, 1'b0};
  logic         ir [2];
  logic         ov [2];
  logic         co [2];
  logic         of [2];
  logic         bz [2];
  logic [W-1:0] sm [2];

  int n_cmp = 0;
  int n_bad = 0;
  int nch [2] = '{7, 3};
  int acc_m [2] = '{0, 0};

  always #5 clk = ~clk;

  carry_ripple_seq_adder #(.WIDTH(W), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .op_a(op_a), .op_b(op_b), .mode(mode),
    .cin(cin), .acc_clr(acc_clr),
    .out_valid(ov[0]), .out_ready(out_ready),
    .sum(sm[0]), .cout(co[0]), .ovf(of[0]),
    .busy(bz[0])
  );

  carry_ripple_seq_adder #(.WIDTH(W), .DIGIT(3)) u_d3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .op_a(op_a), .op_b(op_b), .mode(mode),
    .cin(cin), .acc_clr(acc_clr),
    .out_valid(ov[1]), .out_ready(out_ready),
    .sum(sm[1]), .cout(co[1]), .ovf(of[1]),
    .busy(bz[1])
  );

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] want
  );
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, want);
    end
  endtask

  // Reference: plain integer arithmetic on the mode rules
  task automatic model(
    input  int           d,
    input  logic [1:0]   m,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c,
    output logic [W-1:0] s,
    output logic         cy,
    output logic         v
  );
    int x, y, t, r;
    x  = m[1] ? acc_m[d] : int'(a);
    y  = m[0] ? (MOD - 1 - int'(b)) : int'(b);
    t  = x + y + (m[0] ? 1 : int'(c));
    r  = t % MOD;
    s  = W'(r);
    cy = (t >= MOD);
    v  = ((x >= HALF) == (y >= HALF))
      && ((r >= HALF) != (x >= HALF));
  endtask

  task automatic launch(
    input int           d,
    input logic [1:0]   m,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         c
  );
    mode  = m;
    op_a  = a;
    op_b  = b;
    cin   = c;
    iv[d] = 1'b1;
    check("in_ready_idle", 32'(ir[d]), 1);
    @(posedge clk); #1;
    iv[d] = 1'b0;
  endtask

  task automatic wait_done(
    input  int d,
    output int n
  );
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ov[d] && n < 40);
  endtask

  task automatic collect(
    input int           d,
    input logic [W-1:0] es,
    input logic         ec,
    input logic         ev
  );
    int n;
    wait_done(d, n);
    check("latency", n, nch[d]);
    check("sum", 32'(sm[d]), 32'(es));
    check("cout", 32'(co[d]), 32'(ec));
    check("ovf", 32'(of[d]), 32'(ev));
    check("in_ready_done", 32'(ir[d]), 0);
    if (out_ready) begin
      @(posedge clk); #1;
      check("valid_drop", 32'(ov[d]), 0);
    end
  endtask

  task automatic run(
    input int           d,
    input logic [1:0]   m,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         c
  );
    logic [W-1:0] s;
    logic         cy, v;
    model(d, m, a, b, c, s, cy, v);
    launch(d, m, a, b, c);
    collect(d, s, cy, v);
    acc_m[d] = int'(s);
  endtask

  task automatic clear_acc();
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr  = 1'b0;
    acc_m[0] = 0;
    acc_m[1] = 0;
  endtask

  initial begin
    logic [W-1:0] s1, s2;
    logic         c1, v1, c2, v2;
    int           n;

    #12;
    for (int d = 0; d < 2; d++) begin
      check("rst_in_ready", 32'(ir[d]), 1);
      check("rst_out_valid", 32'(ov[d]), 0);
      check("rst_busy", 32'(bz[d]), 0);
      check("rst_sum", 32'(sm[d]), 0);
      check("rst_cout", 32'(co[d]), 0);
      check("rst_ovf", 32'(of[d]), 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(0, M_ADD, 7'h3F, 7'h01, 1'b0);
    run(0, M_SUB, 7'h05, 7'h07, 1'b0);
    run(0, M_SUB, 7'h07, 7'h05, 1'b0);
    clear_acc();
    repeat (3) run(0, M_AADD, 7'h00, 7'h30, 1'b0);
    run(1, M_ADD, 7'h7F, 7'h01, 1'b0);
    run(1, M_ADD, 7'h3F, 7'h01, 1'b1);

    // clear on the same edge as the acc write
    model(0, M_AADD, 7'h00, 7'h05, 1'b0, s1, c1, v1);
    launch(0, M_AADD, 7'h00, 7'h05, 1'b0);
    repeat (nch[0] - 1) begin
      @(posedge clk); #1;
    end
    check("clr_pre_valid", 32'(ov[0]), 0);
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    check("clr_valid", 32'(ov[0]), 1);
    check("clr_sum", 32'(sm[0]), 32'(s1));
    check("clr_cout", 32'(co[0]), 32'(c1));
    @(posedge clk); #1;
    acc_m[0] = 0;
    acc_m[1] = 0;
    run(0, M_AADD, 7'h00, 7'h05, 1'b0);

    // backpressure with a pending request
    out_ready = 1'b0;
    model(0, M_ADD, 7'h12, 7'h34, 1'b0, s1, c1, v1);
    launch(0, M_ADD, 7'h12, 7'h34, 1'b0);
    wait_done(0, n);
    check("bp_latency", n, nch[0]);
    check("bp_sum0", 32'(sm[0]), 32'(s1));
    acc_m[0] = int'(s1);
    model(0, M_ADD, 7'h55, 7'h11, 1'b0, s2, c2, v2);
    mode  = M_ADD;
    op_a  = 7'h55;
    op_b  = 7'h11;
    iv[0] = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_sum", 32'(sm[0]), 32'(s1));
      check("bp_cout", 32'(co[0]), 32'(c1));
      check("bp_in_ready", 32'(ir[0]), 0);
      check("bp_valid", 32'(ov[0]), 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rel_ready", 32'(ir[0]), 1);
    check("bp_rel_valid", 32'(ov[0]), 0);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    check("bp_acc_busy", 32'(bz[0]), 1);
    check("bp_acc_ready", 32'(ir[0]), 0);
    collect(0, s2, c2, v2);
    acc_m[0] = int'(s2);

    // reset during chunk 3
    launch(0, M_ADD, 7'h21, 7'h13, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("mid_rst_valid", 32'(ov[d]), 0);
      check("mid_rst_ready", 32'(ir[d]), 1);
      check("mid_rst_busy", 32'(bz[d]), 0);
    end
    #2;
    rst_n    = 1'b1;
    acc_m[0] = 0;
    acc_m[1] = 0;
    repeat (10) begin
      @(posedge clk); #1;
      check("post_rst_valid", 32'(ov[0]), 0);
    end
    run(0, M_ADD, 7'h01, 7'h01, 1'b0);
    run(0, M_AADD, 7'h00, 7'h00, 1'b0);
    run(1, M_AADD, 7'h00, 7'h00, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int         d;
      logic [1:0] m;
      d = int'($urandom_range(0, 1));
      m = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) clear_acc();
      run(d, m, W'($urandom), W'($urandom),
          1'($urandom_range(0, 1)));
    end
    run(0, M_ASUB, 7'h00, 7'h7F, 1'b0);
    run(1, M_ASUB, 7'h00, 7'h40, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
